// File: rtl/stream_fork_n_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | stream_fork_n_if : producer and per-channel consumer handshakes     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
interface stream_fork_n_if #(
  parameter int DATA_BW = 8,
  parameter int NUM_OUT = 4
);
  logic [DATA_BW-1:0]         s_data;
  logic [NUM_OUT-1:0]         s_mask;
  logic                       s_valid;
  logic                       s_ready;
  logic [NUM_OUT-1:0]         m_valid;
  logic [NUM_OUT*DATA_BW-1:0] m_data;
  logic [NUM_OUT-1:0]         m_ready;
  logic                       busy;

  modport master (
    output s_data, s_mask, s_valid, m_ready,
    input  s_ready, m_valid, m_data, busy
  );

  modport slave (
    input  s_data, s_mask, s_valid, m_ready,
    output s_ready, m_valid, m_data, busy
  );
endinterface
`default_nettype wire

// File: rtl/stream_fork_branch.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | stream_fork_branch : one output lane, tracks whether it was served  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module stream_fork_branch (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic i_full,
  input  wire logic i_sel,
  input  wire logic i_ready,
  input  wire logic i_clr,
  output logic      o_valid,
  output logic      o_satisfied
);
  logic r_served;
  logic w_fire;

  assign o_valid     = i_full & i_sel & ~r_served;
  assign w_fire      = o_valid & i_ready;
  // Unselected lanes count as satisfied so they never hold the beat.
  assign o_satisfied = r_served | w_fire | ~i_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_served <= 1'b0;
    end else if (i_clr) begin
      r_served <= 1'b0;
    end else if (w_fire) begin
      r_served <= 1'b1;
    end
  end
endmodule
`default_nettype wire

// File: rtl/stream_fork_n.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | stream_fork_n : registered eager fork to a per-beat lane subset     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module stream_fork_n #(
  parameter int DATA_BW = 8,
  parameter int NUM_OUT = 4
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  stream_fork_n_if.slave  bus
);
  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t               r_state;
  logic [DATA_BW-1:0]   r_data;
  logic [NUM_OUT-1:0]   r_mask;
  logic [NUM_OUT-1:0]   w_satisfied;
  logic                 w_full;
  logic                 w_done;
  logic                 w_s_fire;
  logic                 w_clr;

  generate
    if (NUM_OUT < 2 || NUM_OUT > 16) begin : g_bad_num_out
      $error("stream_fork_n: NUM_OUT must be within 2..16");
    end
  endgenerate

  assign w_full   = (r_state == ST_FULL);
  assign w_done   = w_full & (&w_satisfied);
  assign w_s_fire = bus.s_valid & bus.s_ready;
  // Served flags restart whenever a beat retires or a new one loads.
  assign w_clr    = w_done | w_s_fire;

  assign bus.s_ready = ~w_full | w_done;
  assign bus.busy    = w_full;
  assign bus.m_data  = {NUM_OUT{r_data}};

  generate
    for (genvar i = 0; i < NUM_OUT; i++) begin : g_branch
      stream_fork_branch u_branch (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_full      (w_full),
        .i_sel       (r_mask[i]),
        .i_ready     (bus.m_ready[i]),
        .i_clr       (w_clr),
        .o_valid     (bus.m_valid[i]),
        .o_satisfied (w_satisfied[i])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
      r_data  <= '0;
      r_mask  <= '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_s_fire) begin
            r_state <= ST_FULL;
            r_data  <= bus.s_data;
            r_mask  <= bus.s_mask;
          end
        end
        ST_FULL: begin
          if (w_done) begin
            if (w_s_fire) begin
              r_data <= bus.s_data;
              r_mask <= bus.s_mask;
            end else begin
              r_state <= ST_EMPTY;
            end
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_stream_fork_n.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_stream_fork_n : directed scenarios plus randomized model check   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_stream_fork_n;
  localparam int DATA_BW = 8;
  localparam int NUM_OUT = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  stream_fork_n_if #(.DATA_BW(DATA_BW), .NUM_OUT(NUM_OUT)) bus ();

  stream_fork_n #(.DATA_BW(DATA_BW), .NUM_OUT(NUM_OUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DATA_BW-1:0] ch_data(int i);
    return bus.m_data[i*DATA_BW +: DATA_BW];
  endfunction

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic drive(input logic v, input logic [7:0] d, input logic [3:0] m, input logic [3:0] r);
    @(negedge clk);
    bus.s_valid = v;
    bus.s_data  = d;
    bus.s_mask  = m;
    bus.m_ready = r;
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.s_mask = '0; bus.m_ready = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus.m_valid !== 4'h0) begin failures++; $display("FAIL reset_m_valid got=%h exp=0", bus.m_valid); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.s_ready !== 1'b1) begin failures++; $display("FAIL reset_s_ready got=%b exp=1", bus.s_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 8'h00, 4'h0, 4'h0);
    checks++; if (bus.s_ready !== 1'b1 || bus.busy !== 1'b0) begin failures++; $display("FAIL post_reset s_ready=%b busy=%b exp 1/0", bus.s_ready, bus.busy); end
  endtask

  task automatic test_broadcast;
    logic [7:0] beats [3];
    beats[0] = 8'h11; beats[1] = 8'h22; beats[2] = 8'h33;
    for (int c = 0; c < 5; c++) begin
      if (c < 3) drive(1'b1, beats[c], 4'hF, 4'hF);
      else       drive(1'b0, 8'h00, 4'h0, 4'hF);
      if (c < 3) begin
        checks++; if (bus.s_ready !== 1'b1) begin failures++; $display("FAIL bcast_s_ready c=%0d got=%b exp=1", c, bus.s_ready); end
      end
      checks++;
      if (bus.m_valid !== ((c >= 1 && c <= 3) ? 4'hF : 4'h0)) begin
        failures++; $display("FAIL bcast_m_valid c=%0d got=%h", c, bus.m_valid);
      end
      if (c >= 1 && c <= 3) begin
        for (int i = 0; i < NUM_OUT; i++) begin
          checks++; if (ch_data(i) !== beats[c-1]) begin failures++; $display("FAIL bcast_data c=%0d ch=%0d got=%h exp=%h", c, i, ch_data(i), beats[c-1]); end
        end
      end
    end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL bcast_busy_end got=%b exp=0", bus.busy); end
  endtask

  task automatic test_partial_mask;
    drive(1'b1, 8'hA5, 4'b0101, 4'hF);
    drive(1'b0, 8'h00, 4'h0, 4'b1011);
    checks++; if (bus.m_valid !== 4'b0101) begin failures++; $display("FAIL pmask_valid1 got=%b exp=0101", bus.m_valid); end
    checks++; if (ch_data(0) !== 8'hA5) begin failures++; $display("FAIL pmask_data0 got=%h exp=a5", ch_data(0)); end
    checks++; if (bus.s_ready !== 1'b0) begin failures++; $display("FAIL pmask_s_ready1 got=%b exp=0", bus.s_ready); end
    drive(1'b0, 8'h00, 4'h0, 4'b1110);
    checks++; if (bus.m_valid !== 4'b0100) begin failures++; $display("FAIL pmask_valid2 got=%b exp=0100", bus.m_valid); end
    checks++; if (bus.s_ready !== 1'b1) begin failures++; $display("FAIL pmask_s_ready2 got=%b exp=1", bus.s_ready); end
    drive(1'b0, 8'h00, 4'h0, 4'hF);
    checks++; if (bus.m_valid !== 4'h0 || bus.busy !== 1'b0) begin failures++; $display("FAIL pmask_retire valid=%b busy=%b exp 0/0", bus.m_valid, bus.busy); end
  endtask

  task automatic test_split_ready;
    int got [NUM_OUT];
    for (int i = 0; i < NUM_OUT; i++) got[i] = 0;
    drive(1'b1, 8'h3C, 4'hF, 4'h0);
    for (int c = 1; c <= 3; c++) begin
      drive(1'b0, 8'h00, 4'h0, (c == 1) ? 4'b0011 : (c == 2) ? 4'b1100 : 4'hF);
      for (int i = 0; i < NUM_OUT; i++)
        if (bus.m_valid[i] && bus.m_ready[i] && ch_data(i) == 8'h3C) got[i]++;
      if (c == 1) begin
        checks++; if (bus.m_valid !== 4'hF || bus.s_ready !== 1'b0) begin failures++; $display("FAIL split_c1 valid=%b s_ready=%b exp f/0", bus.m_valid, bus.s_ready); end
      end else if (c == 2) begin
        checks++; if (bus.m_valid !== 4'b1100 || bus.s_ready !== 1'b1) begin failures++; $display("FAIL split_c2 valid=%b s_ready=%b exp 1100/1", bus.m_valid, bus.s_ready); end
      end else begin
        checks++; if (bus.m_valid !== 4'h0) begin failures++; $display("FAIL split_c3 valid=%b exp=0", bus.m_valid); end
      end
    end
    for (int i = 0; i < NUM_OUT; i++) begin
      checks++; if (got[i] != 1) begin failures++; $display("FAIL split_once ch=%0d got=%0d exp=1", i, got[i]); end
    end
  endtask

  task automatic test_zero_mask;
    drive(1'b1, 8'hFF, 4'h0, 4'h0);
    checks++; if (bus.s_ready !== 1'b1) begin failures++; $display("FAIL zmask_accept got=%b exp=1", bus.s_ready); end
    drive(1'b1, 8'h77, 4'b0001, 4'h0);
    checks++; if (bus.busy !== 1'b1 || bus.m_valid !== 4'h0 || bus.s_ready !== 1'b1) begin
      failures++; $display("FAIL zmask_drop busy=%b valid=%b s_ready=%b exp 1/0/1", bus.busy, bus.m_valid, bus.s_ready);
    end
    drive(1'b0, 8'h00, 4'h0, 4'h1);
    checks++; if (bus.m_valid !== 4'b0001 || ch_data(0) !== 8'h77) begin failures++; $display("FAIL zmask_next valid=%b data=%h exp 0001/77", bus.m_valid, ch_data(0)); end
    drive(1'b0, 8'h00, 4'h0, 4'h0);
    checks++; if (bus.busy !== 1'b0 || bus.m_valid !== 4'h0) begin failures++; $display("FAIL zmask_end busy=%b valid=%b exp 0/0", bus.busy, bus.m_valid); end
  endtask

  task automatic test_stall;
    logic [7:0] d;
    d = 8'($urandom_range(0, 255));
    drive(1'b1, d, 4'hF, 4'b1011);
    for (int c = 0; c < 20; c++) begin
      drive(1'b0, 8'h00, 4'h0, 4'b1011);
      checks++;
      if (bus.m_valid[2] !== 1'b1 || ch_data(2) !== d || bus.s_ready !== 1'b0) begin
        failures++; $display("FAIL stall c=%0d valid2=%b data2=%h s_ready=%b exp 1/%h/0", c, bus.m_valid[2], ch_data(2), bus.s_ready, d);
      end
    end
    checks++; if (bus.m_valid !== 4'b0100) begin failures++; $display("FAIL stall_others got=%b exp=0100", bus.m_valid); end
    drive(1'b0, 8'h00, 4'h0, 4'hF);
    checks++; if (bus.s_ready !== 1'b1) begin failures++; $display("FAIL stall_release got=%b exp=1", bus.s_ready); end
    drive(1'b0, 8'h00, 4'h0, 4'h0);
  endtask

  task automatic test_async_reset;
    drive(1'b1, 8'h5A, 4'hF, 4'h0);
    drive(1'b0, 8'h00, 4'h0, 4'b0001);
    drive(1'b0, 8'h00, 4'h0, 4'h0);
    checks++; if (bus.m_valid !== 4'b1110) begin failures++; $display("FAIL areset_pre got=%b exp=1110", bus.m_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.m_valid !== 4'h0 || bus.busy !== 1'b0) begin failures++; $display("FAIL areset_now valid=%b busy=%b exp 0/0", bus.m_valid, bus.busy); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 8'h00, 4'h0, 4'hF);
      checks++;
      if (bus.m_valid !== 4'h0 || bus.busy !== 1'b0 || bus.s_ready !== 1'b1) begin
        failures++; $display("FAIL areset_after c=%0d valid=%b busy=%b s_ready=%b exp 0/0/1", c, bus.m_valid, bus.busy, bus.s_ready);
      end
    end
  endtask

  // Reference: one held beat with the set of lanes still owed a copy.
  task automatic test_random;
    logic       hold_valid;
    logic [7:0] hold_data;
    logic [3:0] pending;
    logic       prod_v;
    logic [7:0] prod_d;
    logic [3:0] prod_m;
    logic [3:0] rdy;
    logic [3:0] exp_valid;
    logic [3:0] fired;
    logic       exp_s_ready;
    int         sent [NUM_OUT];
    int         recv [NUM_OUT];
    hold_valid = 1'b0; hold_data = '0; pending = '0;
    prod_v = 1'b0; prod_d = '0; prod_m = '0;
    for (int i = 0; i < NUM_OUT; i++) begin sent[i] = 0; recv[i] = 0; end
    for (int c = 0; c < 400; c++) begin
      if (!prod_v && ($urandom_range(0, 3) != 0)) begin
        prod_v = 1'b1;
        prod_d = 8'($urandom_range(0, 255));
        prod_m = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      end
      rdy = 4'($urandom_range(0, 15));
      drive(prod_v, prod_d, prod_m, rdy);
      exp_valid   = hold_valid ? pending : 4'h0;
      fired       = exp_valid & rdy;
      exp_s_ready = !hold_valid || ((pending & ~fired) == 4'h0);
      checks++; if (bus.m_valid !== exp_valid) begin failures++; $display("FAIL rand_valid c=%0d got=%b exp=%b", c, bus.m_valid, exp_valid); end
      checks++; if (bus.s_ready !== exp_s_ready) begin failures++; $display("FAIL rand_s_ready c=%0d got=%b exp=%b", c, bus.s_ready, exp_s_ready); end
      checks++; if (bus.busy !== hold_valid) begin failures++; $display("FAIL rand_busy c=%0d got=%b exp=%b", c, bus.busy, hold_valid); end
      for (int i = 0; i < NUM_OUT; i++) begin
        if (exp_valid[i]) begin
          checks++; if (ch_data(i) !== hold_data) begin failures++; $display("FAIL rand_data c=%0d ch=%0d got=%h exp=%h", c, i, ch_data(i), hold_data); end
        end
        if (bus.m_valid[i] && rdy[i]) recv[i]++;
      end
      pending = pending & ~fired;
      if (hold_valid && pending == 4'h0) hold_valid = 1'b0;
      if (prod_v && exp_s_ready) begin
        hold_valid = 1'b1;
        hold_data  = prod_d;
        pending    = prod_m;
        for (int i = 0; i < NUM_OUT; i++) if (prod_m[i]) sent[i]++;
        prod_v = 1'b0;
      end
    end
    for (int c = 0; c < 4; c++) begin
      drive(1'b0, 8'h00, 4'h0, 4'hF);
      for (int i = 0; i < NUM_OUT; i++) if (bus.m_valid[i]) recv[i]++;
    end
    for (int i = 0; i < NUM_OUT; i++) begin
      checks++; if (recv[i] != sent[i]) begin failures++; $display("FAIL rand_count ch=%0d got=%0d exp=%0d", i, recv[i], sent[i]); end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_broadcast();
    test_partial_mask();
    test_split_ready();
    test_zero_mask();
    test_stall();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
